// File: rtl/music_player_ctrl.sv
// Beat sequencer for the music box tone path: paces beats off clk with a
// clock-enable style timer and steps the beat index fed to the tone lookup.
module music_player_ctrl #(
    parameter int unsigned HALF_SEC_CYCLES = 50_000_000,
    parameter int unsigned BEAT_LEN        = 128,
    parameter int unsigned IBEAT_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               dir,
    input  logic               loop,
    input  logic [1:0]         speed,
    output logic [IBEAT_W-1:0] ibeat,
    output logic               beat_pulse,
    output logic               tone_en,
    output logic               busy,
    output logic               done
);

    // Wide enough for the slowest beat (speed 3) without truncation.
    localparam int unsigned            PERIOD_W  = $clog2(HALF_SEC_CYCLES * 3 + 1);
    localparam logic [PERIOD_W-1:0]    HALF_P    = PERIOD_W'(HALF_SEC_CYCLES);
    localparam logic [IBEAT_W-1:0]     LAST_BEAT = IBEAT_W'(BEAT_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IBEAT_W-1:0]  r_ibeat;
    logic [IBEAT_W-1:0]  w_ibeat_nxt;
    logic [PERIOD_W-1:0] r_timer;
    logic [PERIOD_W-1:0] w_timer_nxt;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] w_period_nxt;
    logic                w_pulse_nxt;
    logic                w_run;
    logic                w_at_end;
    logic                r_beat_pulse;
    logic                r_tone_en;
    logic                r_busy;
    logic                r_done;

    function automatic logic [PERIOD_W-1:0] f_period(input logic [1:0] spd);
        logic [1:0] eff;
        eff = (spd == 2'd0) ? 2'd1 : spd;
        return HALF_P * PERIOD_W'(eff);
    endfunction

    assign w_at_end = dir ? (r_ibeat == '0) : (r_ibeat == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Resuming from PAUSE counts on the release edge, so a beat always spans
    // exactly period_reg un-paused cycles.
    always_comb begin
        w_state_nxt  = r_state;
        w_ibeat_nxt  = r_ibeat;
        w_timer_nxt  = r_timer;
        w_period_nxt = r_period;
        w_pulse_nxt  = 1'b0;
        w_run        = 1'b0;
        if (stop) begin
            w_state_nxt = S_IDLE;
            w_ibeat_nxt = '0;
            w_timer_nxt = '0;
        end else if (start) begin
            w_state_nxt  = S_PLAY;
            w_ibeat_nxt  = dir ? LAST_BEAT : '0;
            w_timer_nxt  = '0;
            w_period_nxt = f_period(speed);
        end else begin
            case (r_state)
                S_PLAY: begin
                    if (pause) begin
                        w_state_nxt = S_PAUSE;
                    end else begin
                        w_run = 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (!pause) begin
                        w_state_nxt = S_PLAY;
                        w_run       = 1'b1;
                    end
                end
                default: begin
                    w_timer_nxt = '0;
                end
            endcase

            if (w_run) begin
                if (r_timer == r_period - PERIOD_W'(1)) begin
                    w_timer_nxt  = '0;
                    w_period_nxt = f_period(speed);
                    if (w_at_end) begin
                        if (loop) begin
                            w_ibeat_nxt = dir ? LAST_BEAT : '0;
                            w_pulse_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_ibeat_nxt = dir ? (r_ibeat - IBEAT_W'(1)) : (r_ibeat + IBEAT_W'(1));
                        w_pulse_nxt = 1'b1;
                    end
                end else begin
                    w_timer_nxt = r_timer + PERIOD_W'(1);
                end
            end
        end
    end

    // Status flags decode the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ibeat      <= '0;
            r_timer      <= '0;
            r_period     <= HALF_P;
            r_beat_pulse <= 1'b0;
            r_tone_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_ibeat      <= w_ibeat_nxt;
            r_timer      <= w_timer_nxt;
            r_period     <= w_period_nxt;
            r_beat_pulse <= w_pulse_nxt;
            r_tone_en    <= (w_state_nxt == S_PLAY);
            r_busy       <= (w_state_nxt == S_PLAY) || (w_state_nxt == S_PAUSE);
            r_done       <= (w_state_nxt == S_DONE);
        end
    end

    assign ibeat      = r_ibeat;
    assign beat_pulse = r_beat_pulse;
    assign tone_en    = r_tone_en;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_music_player_ctrl.sv
// Directed bench for music_player_ctrl with HALF_SEC_CYCLES = 4, BEAT_LEN = 4.
module tb_music_player_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic       dir;
    logic       loop;
    logic [1:0] speed;
    logic [7:0] ibeat;
    logic       beat_pulse;
    logic       tone_en;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    music_player_ctrl #(
        .HALF_SEC_CYCLES(4),
        .BEAT_LEN       (4),
        .IBEAT_W        (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .dir       (dir),
        .loop      (loop),
        .speed     (speed),
        .ibeat     (ibeat),
        .beat_pulse(beat_pulse),
        .tone_en   (tone_en),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        dir   = 1'b0;
        loop  = 1'b1;
        speed = 2'd1;
        tick();
        tick();
        chk("rst_ibeat", ibeat, 0);
        chk("rst_pulse", beat_pulse, 0);
        chk("rst_tone_en", tone_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // 1: forward loop at speed 1, wrap 3 -> 0
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_start_ibeat", ibeat, 0);
        chk("t1_start_tone", tone_en, 1);
        chk("t1_start_busy", busy, 1);
        for (int k = 1; k <= 4; k++) begin
            repeat (3) begin
                tick();
                chk("t1_hold_ibeat", ibeat, (k - 1) % 4);
                chk("t1_hold_pulse", beat_pulse, 0);
                chk("t1_hold_tone", tone_en, 1);
            end
            tick();
            chk("t1_step_ibeat", ibeat, k % 4);
            chk("t1_step_pulse", beat_pulse, 1);
            chk("t1_step_busy", busy, 1);
        end

        // 2: speed 2 at start, speed 3 mid-beat, then speed 0
        speed = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_start_ibeat", ibeat, 0);
        repeat (3) tick();
        speed = 2'd3;
        repeat (4) tick();
        chk("t2_b8_hold", ibeat, 0);
        tick();
        chk("t2_b8_step", ibeat, 1);
        chk("t2_b8_pulse", beat_pulse, 1);
        repeat (5) tick();
        speed = 2'd0;
        repeat (6) tick();
        chk("t2_b12_hold", ibeat, 1);
        chk("t2_b12_pulse0", beat_pulse, 0);
        tick();
        chk("t2_b12_step", ibeat, 2);
        repeat (3) tick();
        chk("t2_b4_hold", ibeat, 2);
        tick();
        chk("t2_b4_step", ibeat, 3);
        chk("t2_b4_pulse", beat_pulse, 1);

        // 3: reverse one-shot into DONE, restart from DONE
        speed = 2'd1;
        dir   = 1'b1;
        loop  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_start_ibeat", ibeat, 3);
        for (int e = 2; e >= 0; e--) begin
            repeat (4) tick();
            chk("t3_step_ibeat", ibeat, e);
        end
        repeat (3) tick();
        chk("t3_predone", done, 0);
        tick();
        chk("t3_done", done, 1);
        chk("t3_done_tone", tone_en, 0);
        chk("t3_done_busy", busy, 0);
        chk("t3_done_ibeat", ibeat, 0);
        chk("t3_done_pulse", beat_pulse, 0);
        tick();
        chk("t3_done_hold", done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_replay_ibeat", ibeat, 3);
        chk("t3_replay_done", done, 0);
        chk("t3_replay_tone", tone_en, 1);

        // 4: pause 2 cycles into beat 1 for 10 cycles
        dir   = 1'b0;
        loop  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("t4_beat1", ibeat, 1);
        repeat (2) tick();
        pause = 1'b1;
        tick();
        chk("t4_pause_tone", tone_en, 0);
        chk("t4_pause_busy", busy, 1);
        repeat (9) tick();
        chk("t4_pause_ibeat", ibeat, 1);
        chk("t4_pause_tone2", tone_en, 0);
        pause = 1'b0;
        tick();
        chk("t4_resume_ibeat", ibeat, 1);
        chk("t4_resume_tone", tone_en, 1);
        tick();
        chk("t4_resume_step", ibeat, 2);
        chk("t4_resume_pulse", beat_pulse, 1);

        // 5: stop+start together, then reset mid-beat
        tick();
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        chk("t5_stop_busy", busy, 0);
        chk("t5_stop_ibeat", ibeat, 0);
        chk("t5_stop_tone", tone_en, 0);
        tick();
        chk("t5_idle_ibeat", ibeat, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("t5_beat1", ibeat, 1);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rst_ibeat", ibeat, 0);
        chk("t5_rst_pulse", beat_pulse, 0);
        chk("t5_rst_tone", tone_en, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);

        // 6: dir flip mid-beat at ibeat 2, then reverse wrap with loop
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("t6_beat2", ibeat, 2);
        repeat (2) tick();
        dir = 1'b1;
        tick();
        chk("t6_hold", ibeat, 2);
        tick();
        chk("t6_rev_step", ibeat, 1);
        chk("t6_rev_pulse", beat_pulse, 1);
        repeat (4) tick();
        chk("t6_rev_zero", ibeat, 0);
        repeat (4) tick();
        chk("t6_rev_wrap", ibeat, 3);
        chk("t6_rev_wrap_pulse", beat_pulse, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/music_player_ctrl.md
Name: music_player_ctrl

Overview:
- Sequencer for the music box tone path: paces beats from the system clock and steps the beat index that feeds the tone lookup.
- Adds start/stop/pause, direction and loop/one-shot control.
- Gates the tone PWM through tone_en.
- Replaces the divided-clock beat stepper: everything runs on clk and beat advance is a clock-enable.

Parameters:
- HALF_SEC_CYCLES, 50_000_000: clk cycles per 0.5 s; the bench uses 4.
- BEAT_LEN, 128: number of beats in the score, 2..256.
- IBEAT_W, 8: width of ibeat.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle pulse; begins playback from the first beat for the current dir.
- stop  input  1  one-cycle pulse; aborts playback and returns to IDLE.
- pause  input  1  level; holds beat position and timer while high.
- dir  input  1  0 = forward (ibeat increments), 1 = reverse (ibeat decrements).
- loop  input  1  1 = wrap at score end, 0 = one-shot.
- speed  input  2  beat period = 0.5 s × speed; speed 0 is treated as 1.
- ibeat  output  IBEAT_W  current beat index to the tone lookup.
- beat_pulse  output  1  one-cycle pulse on every ibeat change caused by a beat advance.
- tone_en  output  1  high only in PLAY; mutes the tone PWM otherwise.
- busy  output  1  high in PLAY or PAUSE.
- done  output  1  high in DONE.

Behaviour:
- Reset is synchronous, checked first every edge.
  - state = IDLE, ibeat = 0, timer = 0.
  - period_reg = HALF_SEC_CYCLES.
  - beat_pulse, tone_en, busy and done all 0.
- All outputs are registered, so each changes one cycle after the causing edge.
- States are IDLE, PLAY, PAUSE, DONE.
  - IDLE → PLAY on start.
  - DONE → PLAY on start.
  - PLAY → PAUSE when pause = 1.
  - PAUSE → PLAY when pause = 0.
  - PLAY → DONE on a one-shot end.
  - PLAY, PAUSE or DONE → IDLE on stop.
- Priority within one cycle: reset > stop > start > pause > beat advance.
  - stop together with start: stop wins, state goes to IDLE.
  - start in PLAY or PAUSE restarts playback (same load as below).
  - start while pause = 1: loads, then enters PAUSE the following cycle.
- On start, the following are loaded:
  - ibeat = 0 if dir = 0, BEAT_LEN-1 if dir = 1.
  - timer = 0.
  - period_reg = HALF_SEC_CYCLES × max(speed, 1), full-width multiply, no truncation.
- Timer runs only in PLAY and counts 0..period_reg-1.
- When timer = period_reg-1 in PLAY (beat advance):
  - timer returns to 0.
  - period_reg is re-latched from the current speed, so a speed change takes effect at a beat boundary only.
  - ibeat steps by ±1 according to the current dir; a dir change therefore applies at the next advance.
  - beat_pulse = 1 for that one cycle.
- End of score:
  - Forward at ibeat = BEAT_LEN-1, or reverse at ibeat = 0.
  - loop = 1: wraps to 0 (forward) or BEAT_LEN-1 (reverse), with beat_pulse.
  - loop = 0: goes to DONE, ibeat holds its last value, beat_pulse stays 0.
- PAUSE: timer and ibeat are frozen; resuming continues the remaining count with no timer reset.
- stop: goes to IDLE, ibeat = 0, timer = 0.
- In IDLE and DONE, timer is held at 0 and ibeat holds (0 in IDLE).
- Output decode:
  - tone_en = (state == PLAY).
  - busy = PLAY or PAUSE.
  - done = DONE.
- The first beat after start lasts a full period_reg cycles.
- Inputs are assumed synchronous to clk; button debouncing and edge detection are done upstream.

Test Plan (HALF_SEC_CYCLES = 4, BEAT_LEN = 4):
1. Reset, then start with dir = 0, loop = 1, speed = 1:
   - ibeat goes 0 → 1 → 2 → 3 → 0, one step every 4 cycles, with a beat_pulse at each step.
   - tone_en = 1 and busy = 1 throughout.
2. speed = 2 at start, then speed = 3 mid-beat:
   - the current beat completes at 8 cycles.
   - the next beat lasts 12 cycles.
   - speed = 0 gives 4 cycles.
3. Start with dir = 1, loop = 0:
   - ibeat goes 3 → 2 → 1 → 0, then DONE with done = 1, tone_en = 0 and ibeat = 0, with no pulse on entry to DONE.
   - A new start from DONE replays from 3.
4. Pause after 2 cycles into beat 1, hold 10 cycles, release:
   - ibeat stays 1 and tone_en = 0 during the pause.
   - Exactly 2 more cycles elapse before ibeat = 2.
5. Stop and start in the same cycle mid-play → IDLE, ibeat = 0, busy = 0. Then assert reset mid-beat → all outputs return to their reset values on the next edge.
6. Flip dir from 0 to 1 while at ibeat = 2 mid-beat → the next advance gives ibeat = 1.
